result_sink_fifo: RTL
=====================

// Module: result_sink_fifo
// PURPOSE
//  Consumer end of the result valid/data/almfull interface. Captures every cycle the
//  producer FSM drives valid=1 into a FIFO and raises almfull back-pressure before the FIFO fills.
//  Drains to the downstream fabric over a ready/valid port.
//  Sits between the result-producing FSM and the host write path.
// PARAMETERS
//  DW         32  data width of in_data/out_data
//  DEPTH      8   FIFO entries; power of 2, >=4
//  AF_MARGIN  2   free-slot margin for almfull; 1..DEPTH-1; covers producer reaction latency
// PORTS
//  clk        in   1            clock, all logic on posedge
//  reset      in   1            synchronous, active-high
//  in_valid   in   1            producer word valid; each high cycle = one word
//  in_data    in   DW           producer word
//  almfull    out  1            back-pressure to producer, registered
//  out_valid  out  1            head word available
//  out_data   out  DW           head word (FWFT)
//  out_ready  in   1            downstream accepts head this cycle
//  level      out  $clog2(DEPTH)+1  current occupancy
//  overflow   out  1            sticky: a word was dropped because FIFO full
// BEHAVIOUR
//  Reset: ptrs=0, level=0, almfull=0, out_valid=0, overflow=0, out_data don't-care.
//  Reset mid-operation: contents discarded, outputs to reset values next cycle; no partial word survives.
//  push = in_valid && (level<DEPTH || pop); pop = out_valid && out_ready.
//  Push at edge t -> word at out_data, out_valid=1 after edge t (1-cycle latency) if FIFO was empty.
//  out_valid = (level!=0); out_data = mem[rd_ptr]; FWFT, stable while out_valid && !out_ready.
//  Full + push + pop same cycle: both occur, level unchanged, no overflow.
//  Empty + push + out_ready: no pop (out_valid=0), push accepted, level->1.
//  Full + push, no pop: word dropped, overflow<=1 (sticky until reset), level stays DEPTH.
//  Pointers width $clog2(DEPTH), wrap modulo DEPTH naturally; level tracks full/empty unambiguously.
//  level_next = level + push - pop (push/pop as 0/1), never >DEPTH or <0.
//  almfull <= (level_next >= DEPTH-AF_MARGIN); deasserts the cycle after level_next drops below.
//  Producer FSM contract: it parks in RESULT state while almfull=1; sink never stalls in_valid otherwise.
//  Repeated valid cycles with the same data are separate words (no de-duplication).
//  Internal state: FILLING (level<DEPTH-AF_MARGIN), ALMFULL, FULL; state reg drives almfull and
//  overflow detection; transitions follow level_next each cycle; reset -> FILLING.
// CONFIGURATION
//  RESULT_SINK_STATS_EN defined: adds outputs stat_accepted[31:0], stat_dropped[15:0],
//   stat_peak[$clog2(DEPTH):0]; accepted++ per push, dropped++ per dropped word (saturating),
//   peak = max level seen; all reset to 0 with reset.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package result_sink_pkg: state enum {SINK_FILLING, SINK_ALMFULL, SINK_FULL}, default widths.
//  Sub-module sink_fifo_mem: DEPTH x DW array, 1 write port (we, waddr, wdata), async read (raddr).
//  Top holds pointers, level, FSM, almfull/overflow regs, optional stats.
// TESTING
//  1 reset, 3 in_valid pulses data 1,2,3, out_ready=0 -> level=3, out_data=1, almfull=0.
//  2 6 pushes (DEPTH=8,AF_MARGIN=2), out_ready=0 -> almfull=1 on cycle after 6th push; 7th,8th accepted.
//  3 9th push while full, no pop -> dropped, overflow=1, level=8, out_data unchanged.
//  4 full, in_valid=1 & out_ready=1 for 4 cycles -> 4 in/4 out, level=8, overflow=0, order kept.
//  5 drain 8 words with out_ready=1 -> values in push order, almfull falls when level_next=5.
//  6 reset asserted with level=5 -> next cycle level=0, out_valid=0, almfull=0, overflow=0.

Source files
------------

// File: rtl/result_sink_pkg.sv
// Shared types and default sizing for the result sink FIFO.
package result_sink_pkg;

  typedef enum logic [1:0] {
    SINK_FILLING = 2'd0,
    SINK_ALMFULL = 2'd1,
    SINK_FULL    = 2'd2
  } sink_state_e;

  localparam int DEF_DW        = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_MARGIN = 2;

endpackage

// File: rtl/sink_fifo_mem.sv
// Storage array for the result sink: one synchronous write port, asynchronous read.
module sink_fifo_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_sink_fifo.sv
// Result sink: captures producer words into a FWFT FIFO with registered almfull back-pressure.
// Define RESULT_SINK_STATS_EN to add accepted/dropped/peak statistics outputs.
module result_sink_fifo
  import result_sink_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     almfull,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output sink_state_e              state
`ifdef RESULT_SINK_STATS_EN
  ,
  output logic [31:0]              stat_accepted,
  output logic [15:0]              stat_dropped,
  output logic [$clog2(DEPTH):0]   stat_peak
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);

  // Handshake: a word moves in on any in_valid cycle with room (or a same-cycle pop),
  // and out on a cycle where out_valid && out_ready; nothing else transfers data.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_next;
  logic          push, pop, drop, full;
  sink_state_e   state_next;

  assign out_valid  = (level != '0);
  assign pop        = out_valid && out_ready;
  assign push       = in_valid && (!full || pop);
  assign drop       = in_valid && full && !pop;
  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (reset) state <= SINK_FILLING;
    else       state <= state_next;
  end

  always_comb begin
    state_next = SINK_FILLING;
    if (level_next >= FULL_LVL)    state_next = SINK_FULL;
    else if (level_next >= AF_LVL) state_next = SINK_ALMFULL;
  end

  // The state register already reflects level_next of the previous edge, so almfull is registered.
  always_comb begin
    almfull = (state != SINK_FILLING);
    full    = (state == SINK_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_next;
      overflow <= overflow | drop;
    end
  end

  sink_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

`ifdef RESULT_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
      stat_peak     <= '0;
    end else begin
      if (push) stat_accepted <= stat_accepted + 32'd1;
      if (drop && (stat_dropped != '1)) stat_dropped <= stat_dropped + 16'd1;
      if (level_next > stat_peak) stat_peak <= level_next;
    end
  end
`endif

endmodule
